// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory port, redirect input and decode handshake.
// master is the fetch stage; slave is the memory/decode/branch side.
interface instr_fetch_if #(
  parameter int unsigned PC_W = 8
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_rdata;
  logic            imem_valid;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic [15:0]     instr;
  logic [PC_W-1:0] instr_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata, imem_valid,
    input  redirect, redirect_pc,
    output instr_valid, instr, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata, imem_valid,
    output redirect, redirect_pc,
    input  instr_valid, instr, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, single-outstanding imem reads, small instruction FIFO to decode,
// branch redirect that flushes buffered and in-flight instructions.
module instr_fetch #(
  parameter int unsigned    PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned    DEPTH    = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  instr_fetch_if.master   bus
);
  localparam int unsigned PTR_W = (DEPTH > 2) ? 2 : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [PC_W-1:0]  r_fetch_pc;
  logic [PC_W-1:0]  r_req_pc;
  logic [PC_W-1:0]  r_buf_pc    [DEPTH];
  logic [15:0]      r_buf_instr [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_req;
  logic             w_enq;
  logic             w_deq;
  logic             w_instr_valid;

  assign w_instr_valid = (r_count != '0);
  assign w_deq         = w_instr_valid && bus.instr_ready;
  assign w_req         = (r_state == S_FETCH) && (r_count < CNT_W'(DEPTH))
                         && !bus.redirect && !i_rst;

  // Next state; a redirect turns an outstanding kept response into one to discard.
  always_comb begin
    w_state_nxt = r_state;
    w_enq       = 1'b0;
    case (r_state)
      S_FETCH: if (w_req) w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.imem_valid) begin
          w_state_nxt = S_FETCH;
          w_enq       = !bus.redirect;
        end else if (bus.redirect) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: if (bus.imem_valid) w_state_nxt = S_FETCH;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_FETCH;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (bus.redirect) begin
        r_fetch_pc <= bus.redirect_pc;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_count    <= '0;
      end else begin
        if (w_req) begin
          r_req_pc   <= r_fetch_pc;
          r_fetch_pc <= r_fetch_pc + PC_W'(1);
        end
        if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        if (w_enq && !w_deq)      r_count <= r_count + CNT_W'(1);
        else if (!w_enq && w_deq) r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Buffer storage needs no reset; count qualifies every entry.
  always_ff @(posedge i_clk) begin
    if (w_enq && !i_rst) begin
      r_buf_pc[r_wr_ptr]    <= r_req_pc;
      r_buf_instr[r_wr_ptr] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_fetch_pc;
  assign bus.instr_valid = w_instr_valid;
  assign bus.instr       = w_instr_valid ? r_buf_instr[r_rd_ptr] : 16'hF000;
  assign bus.instr_pc    = w_instr_valid ? r_buf_pc[r_rd_ptr] : '0;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory model returns 16'h1000|addr after a set latency.
module tb_instr_fetch;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   lat;
  int   reqs;
  logic mpend;
  int   mcnt;
  logic [7:0] maddr;

  instr_fetch_if #(.PC_W(8)) bus ();

  instr_fetch #(.PC_W(8), .RESET_PC(8'h00), .DEPTH(2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: one response per request, lat cycles later.
  always @(posedge clk) begin
    if (rst) begin
      mpend           <= 1'b0;
      mcnt            <= 0;
      maddr           <= '0;
      bus.imem_valid  <= 1'b0;
      bus.imem_rdata  <= '0;
    end else begin
      bus.imem_valid <= 1'b0;
      if (mpend) begin
        if (mcnt <= 1) begin
          bus.imem_valid <= 1'b1;
          bus.imem_rdata <= 16'h1000 | {8'h00, maddr};
          mpend          <= 1'b0;
        end else begin
          mcnt <= mcnt - 1;
        end
      end
      if (bus.imem_req) begin
        if (lat <= 1) begin
          bus.imem_valid <= 1'b1;
          bus.imem_rdata <= 16'h1000 | {8'h00, bus.imem_addr};
        end else begin
          mpend <= 1'b1;
          mcnt  <= lat - 1;
          maddr <= bus.imem_addr;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [7:0] pc);
    chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
    chk({tag, "_instr"}, 32'(bus.instr), 32'(16'h1000 | {8'h00, pc}));
    chk({tag, "_pc"},    32'(bus.instr_pc), 32'(pc));
  endtask

  task automatic chk_req(input string tag, input logic [7:0] addr);
    chk({tag, "_req"},  32'(bus.imem_req), 32'd1);
    chk({tag, "_addr"}, 32'(bus.imem_addr), 32'(addr));
  endtask

  // Holds rst for a few cycles and checks reset outputs; rst is still high on return.
  task automatic do_reset();
    rst              = 1'b1;
    bus.redirect     = 1'b0;
    bus.redirect_pc  = '0;
    bus.instr_ready  = 1'b1;
    nxt(); nxt(); nxt();
    chk("rst_req",   32'(bus.imem_req), 32'd0);
    chk("rst_addr",  32'(bus.imem_addr), 32'h00);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", 32'(bus.instr), 32'h0000F000);
    chk("rst_pc",    32'(bus.instr_pc), 32'd0);
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    lat             = 1;
    rst             = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.instr_ready = 1'b0;

    // Streaming, 1-cycle memory: one instruction per two cycles.
    do_reset();
    lat = 1;
    nxt(); rst = 1'b0; bus.instr_ready = 1'b1; #1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin nxt(); #1; end
      chk_req("strm", 8'(k));
      if (k > 0) chk_head("strm", 8'(k - 1));
      nxt(); #1;
      chk("strm_idle_req", 32'(bus.imem_req), 32'd0);
      chk("strm_idle_valid", 32'(bus.instr_valid), 32'd0);
    end

    // Back-pressure: exactly DEPTH requests, then drain in order and resume at 0x02.
    do_reset();
    nxt(); rst = 1'b0; bus.instr_ready = 1'b0; #1;
    reqs = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin nxt(); #1; end
      reqs += int'(bus.imem_req);
      if (c >= 4) chk_head("full_hold", 8'h00);
    end
    chk("full_reqs", 32'(reqs), 32'd2);
    nxt(); bus.instr_ready = 1'b1; #1;
    chk("full_noreq", 32'(bus.imem_req), 32'd0);
    chk_head("drain0", 8'h00);
    nxt(); #1;
    chk_head("drain1", 8'h01);
    chk_req("resume", 8'h02);
    nxt(); #1;
    chk("drain_empty", 32'(bus.instr_valid), 32'd0);
    nxt(); #1;
    chk_head("drain2", 8'h02);

    // Redirect in FETCH with two entries buffered.
    do_reset();
    nxt(); rst = 1'b0; bus.instr_ready = 1'b0; #1;
    repeat (4) nxt();
    nxt(); bus.redirect = 1'b1; bus.redirect_pc = 8'h40; #1;
    chk("rdf_noreq", 32'(bus.imem_req), 32'd0);
    nxt(); bus.redirect = 1'b0; bus.instr_ready = 1'b1; #1;
    chk("rdf_flushed", 32'(bus.instr_valid), 32'd0);
    chk_req("rdf", 8'h40);
    nxt(); #1;
    nxt(); #1;
    chk_head("rdf_first", 8'h40);

    // 3-cycle memory, redirect while waiting: stale 0x05 response is drained.
    do_reset();
    lat = 3;
    nxt(); rst = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 8'h05; #1;
    chk("rdw_r0_noreq", 32'(bus.imem_req), 32'd0);
    nxt(); bus.redirect = 1'b0; #1;
    chk_req("rdw_05", 8'h05);
    nxt(); bus.redirect = 1'b1; bus.redirect_pc = 8'h80; #1;
    chk("rdw_r1_noreq", 32'(bus.imem_req), 32'd0);
    nxt(); bus.redirect = 1'b0; #1;
    chk("rdw_drain_req3", 32'(bus.imem_req), 32'd0);
    nxt(); #1;
    chk("rdw_drain_req4", 32'(bus.imem_req), 32'd0);
    nxt(); #1;
    chk_req("rdw_80", 8'h80);
    for (int c = 5; c < 9; c++) begin
      if (c > 5) begin nxt(); #1; end
      chk("rdw_no_stale", 32'(bus.instr_valid), 32'd0);
    end
    nxt(); #1;
    chk_head("rdw_first", 8'h80);

    // Redirect coincident with response, then coincident with dequeue.
    do_reset();
    lat = 1;
    nxt(); rst = 1'b0; bus.instr_ready = 1'b1; #1;
    chk_req("rdv_0", 8'h00);
    nxt(); bus.redirect = 1'b1; bus.redirect_pc = 8'h20; #1;
    chk("rdv_noreq", 32'(bus.imem_req), 32'd0);
    nxt(); bus.redirect = 1'b0; bus.instr_ready = 1'b0; #1;
    chk("rdv_dropped", 32'(bus.instr_valid), 32'd0);
    chk_req("rdv_20", 8'h20);
    nxt(); nxt(); nxt(); #1;
    chk_head("rdv_buf", 8'h20);
    nxt(); bus.instr_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 8'h30; #1;
    chk_head("rdq_before", 8'h20);
    nxt(); bus.redirect = 1'b0; #1;
    chk("rdq_flushed", 32'(bus.instr_valid), 32'd0);
    chk_req("rdq_30", 8'h30);
    nxt(); nxt(); #1;
    chk_head("rdq_first", 8'h30);
    nxt(); nxt(); #1;
    chk_head("rdq_second", 8'h31);

    // PC wrap, then reset mid-WAIT.
    do_reset();
    nxt(); rst = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 8'hFE; #1;
    nxt(); bus.redirect = 1'b0; #1;
    chk_req("wrap_fe", 8'hFE);
    nxt(); nxt(); #1;
    chk_head("wrap_hfe", 8'hFE);
    chk_req("wrap_ff", 8'hFF);
    nxt(); nxt(); #1;
    chk_head("wrap_hff", 8'hFF);
    chk_req("wrap_00", 8'h00);
    nxt(); rst = 1'b1; #1;
    chk("mrst_req", 32'(bus.imem_req), 32'd0);
    nxt(); #1;
    chk("mrst_req1",  32'(bus.imem_req), 32'd0);
    chk("mrst_addr",  32'(bus.imem_addr), 32'h00);
    chk("mrst_valid", 32'(bus.instr_valid), 32'd0);
    chk("mrst_instr", 32'(bus.instr), 32'h0000F000);
    chk("mrst_pc",    32'(bus.instr_pc), 32'd0);
    nxt(); rst = 1'b0; #1;
    chk_req("mrst_restart", 8'h00);
    nxt(); nxt(); #1;
    chk_head("mrst_first", 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
